// File: rtl/brainfuck_uart_tx_pkg.sv
// Shared constants for the brainfuck stdout UART transmitter: FSM state
// encodings and the parity mode codes.
package brainfuck_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Parity bit for a byte: even mode makes the total count of ones even,
  // odd mode makes it odd.
  function automatic logic parity_bit(input logic [7:0] b, input int mode);
    return (mode == PARITY_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/brainfuck_uart_tx_if.sv
// Core-to-UART stdout handshake: one-cycle write strobe plus data byte from
// the core, busy back from the transmitter.
interface brainfuck_uart_tx_if #(
  parameter int MEM_DATA_WIDTH = 8
);
  logic                      tx_wr;
  logic [MEM_DATA_WIDTH-1:0] tx_data;
  logic                      tx_busy;

  modport master (output tx_wr, output tx_data, input tx_busy);
  modport slave  (input tx_wr, input tx_data, output tx_busy);
endinterface

// File: rtl/brainfuck_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period.
module brainfuck_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;
  logic          terminal;

  assign terminal = (count_q == TERMINAL);
  assign bit_tick = enable && terminal;

  // Next count: restart wins, otherwise advance and wrap at terminal count.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (enable) begin
      count_d = terminal ? '0 : count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/brainfuck_uart_tx.sv
// UART transmitter acting as the brainfuck core's stdout. Accepts one byte
// per tx_wr while idle and sends start, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits. txd and tx_busy are registered.
module brainfuck_uart_tx
  import brainfuck_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int PARITY_MODE    = PARITY_NONE,
  parameter int STOP_BITS      = 1
) (
  input  logic                clk,
  input  logic                rst,
  brainfuck_uart_tx_if.slave  bus,
  output logic                txd,
  output logic                overrun,
  output logic [2:0]          debug_state
);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [MEM_DATA_WIDTH-1:0] data_in;
  logic                      accept;
  logic                      bit_tick;

  assign data_in = bus.tx_data;
  assign accept  = (state_q == S_IDLE) && bus.tx_wr;

  brainfuck_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q != S_IDLE),
    .restart (accept),
    .bit_tick(bit_tick)
  );

  // Next-state and next-output logic; txd_d is the level for the next cycle
  // so the line changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    overrun_d = overrun_q | (bus.tx_wr & busy_q);
    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_wr) begin
          shift_d   = data_in[7:0];
          parity_d  = parity_bit(data_in[7:0], PARITY_MODE);
          bit_idx_d = '0;
          state_d   = S_START;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
          txd_d     = 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_tick) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_idx_d = '0;
            busy_d    = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset drops the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.tx_busy = busy_q;
  assign txd         = txd_q;
  assign overrun     = overrun_q;
  assign debug_state = state_q;
endmodule
